// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART TX among NUM_REQ byte producers, with a Busy watchdog
module uart_tx_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int IDX_W      = 2,
    parameter int TIMEOUT    = 4
) (
    input  logic                          clk,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            Req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data,
    input  logic                          Tx_Busy,
    output logic [NUM_REQ-1:0]            Ack,
    output logic [NUM_REQ-1:0]            Grant,
    output logic [IDX_W-1:0]              Owner,
    output logic [DATA_WIDTH-1:0]         P_Data,
    output logic                          Data_Valid,
    output logic                          Timeout_Err
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] off;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] nxt;
    logic [NUM_REQ-1:0] rot;
    logic [IDX_W:0]   sum;
    logic [CW-1:0]    cnt;

    // winner = first requester at or after ptr (modulo NUM_REQ); nxt = pointer after the current owner
    always_comb begin
        rot = NUM_REQ'({Req, Req} >> ptr);
        off = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) off = rot[i] ? IDX_W'(i) : off;
        sum = {1'b0, ptr} + {1'b0, off};
        win = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ)) : IDX_W'(sum);
        nxt = (Owner == IDX_W'(NUM_REQ - 1)) ? '0 : Owner + 1'b1;
    end

    // arbitration, one-frame-per-grant sequencing and Busy watchdog; all outputs registered
    always_ff @(posedge clk) begin
        if (RST) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            Ack         <= '0;
            Grant       <= '0;
            Owner       <= '0;
            P_Data      <= '0;
            Data_Valid  <= 1'b0;
            Timeout_Err <= 1'b0;
        end else begin
            Ack         <= '0;
            Data_Valid  <= 1'b0;
            Timeout_Err <= 1'b0;
            case (state)
                IDLE: if (!Tx_Busy && |Req) begin
                    P_Data <= Req_Data[DATA_WIDTH*win +: DATA_WIDTH];
                    Grant  <= NUM_REQ'(1) << win;
                    Ack    <= NUM_REQ'(1) << win;
                    Owner  <= win;
                    state  <= ISSUE;
                end
                ISSUE: begin
                    Data_Valid <= 1'b1;
                    cnt        <= '0;
                    state      <= WAIT_BUSY;
                end
                WAIT_BUSY: if (Tx_Busy) begin
                    state <= WAIT_DONE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    Timeout_Err <= 1'b1;
                    Grant       <= '0;
                    ptr         <= nxt;
                    state       <= IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                WAIT_DONE: if (!Tx_Busy) begin
                    Grant <= '0;
                    ptr   <= nxt;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
